// File: rtl/rr_arb2_pkg.sv
// Shared types and default sizing for the two-requester round-robin burst arbiter.
package rr_arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BEATS = 16;

endpackage

// File: rtl/rr_arb2_mux21_w.sv
// Width-parameterised 2:1 mux steering {last, data} from the granted requester.
module mux21_w #(
  parameter int W = 9
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/rr_arb2.sv
// Two-requester burst arbiter: the grant is held for a whole burst, the round-robin
// pointer flips on release, and over-long bursts are cut at MAX_BEATS.
module rr_arb2
  import rr_arb2_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              err_overrun
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(MAX_BEATS - 1);

  state_t           state, next_state;
  logic             prio;
  logic [CNT_W-1:0] beat_cnt;
  logic             handshake;
  logic             cur_last;
  logic             release_last;
  logic             release_force;
  logic [DATA_W:0]  mux_y;

  // Handshake qualification for whichever requester currently owns the channel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    handshake = 1'b0;
    cur_last  = 1'b0;
    unique case (state)
      GNT0: begin
        handshake = in0_valid & out_ready;
        cur_last  = in0_last;
      end
      GNT1: begin
        handshake = in1_valid & out_ready;
        cur_last  = in1_last;
      end
      default: ;
    endcase
  end

  assign release_last  = handshake & cur_last;
  assign release_force = handshake & ~cur_last & (beat_cnt == CNT_FINAL);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (in0_valid && in1_valid) next_state = prio ? GNT1 : GNT0;
        else if (in0_valid)         next_state = GNT0;
        else if (in1_valid)         next_state = GNT1;
      end
      GNT0, GNT1: begin
        if (release_last || release_force) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic; outputs are forced quiet while reset is asserted even if state is still a grant.
  always_comb begin
    out_valid = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    unique case (state)
      GNT0: begin
        out_valid = in0_valid & ~rst;
        in0_ready = out_ready & ~rst;
      end
      GNT1: begin
        out_valid = in1_valid & ~rst;
        in1_ready = out_ready & ~rst;
      end
      default: ;
    endcase
  end

  // Pointer, beat counter, registered select and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio        <= 1'b0;
      beat_cnt    <= '0;
      sel         <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      sel         <= (next_state == GNT1);
      err_overrun <= release_force;
      if (release_last || release_force) begin
        beat_cnt <= '0;
        prio     <= (state == GNT0);
      end else if (handshake) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  mux21_w #(
    .W(DATA_W + 1)
  ) u_mux (
    .sel(sel),
    .a  ({in0_last, in0_data}),
    .b  ({in1_last, in1_data}),
    .y  (mux_y)
  );

  assign out_last = mux_y[DATA_W];
  assign out_data = mux_y[DATA_W-1:0];

endmodule

// File: tb/tb_rr_arb2.sv
// Directed, table-driven bench for rr_arb2 with MAX_BEATS=4 so forced release is reachable.
module tb_rr_arb2;

  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in0_valid, in0_last, in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in1_valid, in1_last, in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              out_valid, out_last, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              sel, err_overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ol;
    logic       e_r0;
    logic       e_r1;
    logic       e_sel;
    logic       e_err;
  } vec_t;

  rr_arb2 #(
    .DATA_W   (DATA_W),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in0_valid  (in0_valid),
    .in0_data   (in0_data),
    .in0_last   (in0_last),
    .in0_ready  (in0_ready),
    .in1_valid  (in1_valid),
    .in1_data   (in1_data),
    .in1_last   (in1_last),
    .in1_ready  (in1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .sel        (sel),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] d0, input logic l0,
                              input logic v1, input logic [7:0] d1, input logic l1, input logic ordy,
                              input logic ov, input logic [7:0] od, input logic ol, input logic r0,
                              input logic r1, input logic s, input logic e);
    vec_t v;
    v.rst = r;   v.v0 = v0;  v.d0 = d0;  v.l0 = l0;
    v.v1 = v1;   v.d1 = d1;  v.l1 = l1;  v.ordy = ordy;
    v.e_ov = ov; v.e_od = od; v.e_ol = ol; v.e_r0 = r0;
    v.e_r1 = r1; v.e_sel = s; v.e_err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the edge.
  task automatic apply(input vec_t v, input string tag);
    rst       = v.rst;
    in0_valid = v.v0;  in0_data = v.d0;  in0_last = v.l0;
    in1_valid = v.v1;  in1_data = v.d1;  in1_last = v.l1;
    out_ready = v.ordy;
    #1;
    check({tag, ".out_valid"},   32'(out_valid),   32'(v.e_ov));
    check({tag, ".out_data"},    32'(out_data),    32'(v.e_od));
    check({tag, ".out_last"},    32'(out_last),    32'(v.e_ol));
    check({tag, ".in0_ready"},   32'(in0_ready),   32'(v.e_r0));
    check({tag, ".in1_ready"},   32'(in1_ready),   32'(v.e_r1));
    check({tag, ".sel"},         32'(sel),         32'(v.e_sel));
    check({tag, ".err_overrun"}, 32'(err_overrun), 32'(v.e_err));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // Fields: rst, v0,d0,l0, v1,d1,l1, out_ready | out_valid,out_data,out_last, in0_ready,in1_ready, sel, err
    tbl.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0, 0,0));  // reset
    // Single requester, 3-beat burst
    tbl.push_back(mk(0, 1,8'h11,0, 0,8'h00,0, 1,  0,8'h11,0, 0,0, 0,0));  // IDLE, grant next
    tbl.push_back(mk(0, 1,8'h11,0, 0,8'h00,0, 1,  1,8'h11,0, 1,0, 0,0));
    tbl.push_back(mk(0, 1,8'h22,0, 0,8'h00,0, 1,  1,8'h22,0, 1,0, 0,0));
    tbl.push_back(mk(0, 1,8'h33,1, 0,8'h00,0, 1,  1,8'h33,1, 1,0, 0,0));
    tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0, 0,0));  // back in IDLE
    // prio is now 1: contention goes to requester 1
    tbl.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1,  0,8'hA0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 1,8'hA0,0, 1,8'hB0,0, 1,  1,8'hB0,0, 0,1, 1,0));  // beat 1
    // Reset during beat 2: outputs quiet, select still reflects the old grant
    tbl.push_back(mk(1, 1,8'hA0,0, 1,8'hB1,0, 1,  0,8'hB1,0, 0,0, 1,0));
    // After reset prio=0: strict alternation over 4 single-beat bursts
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(0, 1,8'h01,1, 1,8'h02,1, 1,  0,8'h01,1, 0,0, 0,0));
      tbl.push_back(mk(0, 1,8'h01,1, 1,8'h02,1, 1,  1,8'h01,1, 1,0, 0,0));
      tbl.push_back(mk(0, 1,8'h01,1, 1,8'h02,1, 1,  0,8'h01,1, 0,0, 0,0));
      tbl.push_back(mk(0, 1,8'h01,1, 1,8'h02,1, 1,  1,8'h02,1, 0,1, 1,0));
    end
    tbl.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0, 0,0));

    rst = 1'b1;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Stall under GNT1: data held, no ready, counter frozen
    apply(mk(0, 0,8'h00,0, 1,8'hA5,0, 0,  0,8'h00,0, 0,0, 0,0), "stall.idle");
    for (int i = 0; i < 5; i++) begin
      apply(mk(0, 0,8'h00,0, 1,8'hA5,0, 0,  1,8'hA5,0, 0,0, 1,0), $sformatf("stall[%0d]", i));
      check($sformatf("stall[%0d].beat_cnt", i), 32'(dut.beat_cnt), 32'd0);
    end
    apply(mk(0, 0,8'h00,0, 1,8'hA5,1, 1,  1,8'hA5,1, 0,1, 1,0), "stall.release");

    // Forced release after MAX_BEATS beats without last; requester 1 wins next
    apply(mk(0, 1,8'h40,0, 0,8'h00,0, 1,  0,8'h40,0, 0,0, 0,0), "ovr.idle");
    for (int i = 1; i <= MAX_BEATS; i++) begin
      logic [7:0] d;
      d = 8'(8'h40 + i);
      apply(mk(0, 1,d,0, 0,8'h00,0, 1,  1,d,0, 1,0, 0,0), $sformatf("ovr.beat%0d", i));
    end
    check("ovr.beat_cnt_cleared", 32'(dut.beat_cnt), 32'd0);
    apply(mk(0, 1,8'h45,0, 1,8'hE1,1, 1,  0,8'h45,0, 0,0, 0,1), "ovr.pulse");
    apply(mk(0, 1,8'h45,0, 1,8'hE1,1, 1,  1,8'hE1,1, 0,1, 1,0), "ovr.gnt1");

    // Requester 0 goes quiet mid-burst; grant held, requester 1 locked out
    apply(mk(0, 1,8'hC1,0, 1,8'hD1,1, 1,  0,8'hC1,0, 0,0, 0,0), "hold.idle");
    apply(mk(0, 1,8'hC1,0, 1,8'hD1,1, 1,  1,8'hC1,0, 1,0, 0,0), "hold.beat1");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0,8'hC2,0, 1,8'hD1,1, 1,  0,8'hC2,0, 1,0, 0,0), $sformatf("hold.gap%0d", i));
    apply(mk(0, 1,8'hC2,1, 1,8'hD1,1, 1,  1,8'hC2,1, 1,0, 0,0), "hold.beat2");
    apply(mk(0, 1,8'hC3,0, 1,8'hD1,1, 1,  0,8'hC3,0, 0,0, 0,0), "hold.idle2");
    apply(mk(0, 1,8'hC3,0, 1,8'hD1,1, 1,  1,8'hD1,1, 0,1, 1,0), "hold.gnt1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb2.md
RR_ARB2 -- requirements
Module: rr_arb2

Interface
REQ-001 Parameter DATA_W, default 8, sets the payload width of both inputs and the output.
REQ-002 Parameter MAX_BEATS, default 16, sets the maximum number of beats per burst before forced release.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, is a synchronous active-high reset.
REQ-005 Port in0_valid, input, 1: requester 0 has a beat.
REQ-006 Port in0_data, input, DATA_W: requester 0 payload.
REQ-007 Port in0_last, input, 1: the current beat is the final beat of requester 0's burst.
REQ-008 Port in0_ready, output, 1: requester 0 beat is accepted this cycle.
REQ-009 Ports in1_valid, in1_data, in1_last and in1_ready SHALL mirror REQ-005 to REQ-008 for requester 1.
REQ-010 Port out_valid, output, 1: a shared channel beat is present.
REQ-011 Port out_data, output, DATA_W: shared channel payload.
REQ-012 Port out_last, output, 1: final beat of the forwarded burst.
REQ-013 Port out_ready, input, 1: the downstream sink accepts the beat.
REQ-014 Port sel, output, 1: current mux select (0 = requester 0), registered.
REQ-015 Port err_overrun, output, 1: single-cycle pulse on forced release.

Function
REQ-016 The FSM SHALL have states IDLE, GNT0 and GNT1; the encoding is held in the package.
REQ-017 IDLE behaviour:
- out_valid=0, in0_ready=0, in1_ready=0.
- Next state is chosen from the requests sampled this cycle.
REQ-018 IDLE arbitration: if exactly one inX_valid is high, the next state is GNTX.
REQ-019 IDLE, both valid: go to GNT(prio), where prio is a 1-bit round-robin pointer; reset value is 0.
REQ-020 IDLE, neither valid: remain in IDLE.
REQ-021 Grant latency: one cycle from the first valid in IDLE to the first possible beat transfer.
REQ-022 In GNTX, the datapath SHALL pass through combinationally:
- out_valid=inX_valid, out_data=inX_data, out_last=inX_last.
- inX_ready=out_ready; the non-granted ready=0.
REQ-023 sel SHALL equal 1 only in GNT1; it is 0 in IDLE and GNT0.
REQ-024 A handshake is inX_valid & out_ready while in GNTX.
- Each handshake increments beat_cnt (width $clog2(MAX_BEATS+1)).
REQ-025 A handshake with inX_last=1 SHALL:
- return the FSM to IDLE;
- clear beat_cnt;
- set prio to ~X.
REQ-026 Forced release: a handshake with last=0 that makes beat_cnt reach MAX_BEATS SHALL:
- return the FSM to IDLE;
- clear beat_cnt;
- set prio to ~X;
- pulse err_overrun for exactly the next cycle.
REQ-027 In GNTX, inX_valid deasserting mid-burst SHALL NOT release the grant; the FSM waits in GNTX indefinitely.
REQ-028 Requests from the non-granted requester SHALL be ignored until the FSM returns to IDLE.
REQ-029 out_data SHALL remain stable while out_valid=1 and out_ready=0, provided the requester holds its data stable.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL enter the reset state regardless of current state, including mid-burst:
- state=IDLE, prio=0, beat_cnt=0, sel=0, err_overrun=0.
REQ-031 During and in the cycle after reset, out_valid, in0_ready and in1_ready SHALL be 0.

Structure
REQ-032 Package rr_arb2_pkg SHALL hold:
- the state enum (IDLE, GNT0, GNT1);
- the default DATA_W and MAX_BEATS constants.
REQ-033 The payload/last steering SHALL be one sub-module, mux21_w: a DATA_W+1-bit 2:1 mux driven by sel.
REQ-034 The FSM, the prio pointer and beat_cnt SHALL live in rr_arb2.

Verification
REQ-035 Only in0_valid high with a 3-beat burst (data 0x11, 0x22, 0x33; last on 0x33), out_ready=1:
- first beat out one cycle later;
- 3 consecutive out beats;
- back to IDLE;
- prio=1.
REQ-036 Both valid in the same cycle after reset:
- GNT0 first;
- after that burst ends, GNT1 serves requester 1;
- strict alternation over 4 bursts.
REQ-037 GNT1, out_ready held 0 for 5 cycles with in1_data=0xA5:
- out_data stays 0xA5;
- in1_ready=0;
- beat_cnt unchanged.
REQ-038 MAX_BEATS=4, requester 0 streams without last:
- after the 4th handshake: IDLE;
- err_overrun=1 for exactly one cycle;
- requester 1 granted next if valid.
REQ-039 rst asserted during beat 2 of a burst:
- next cycle: IDLE, out_valid=0, sel=0, prio=0;
- after rst drops, requester 0 wins when both are valid.
REQ-040 GNT0 with in0_valid dropping for 3 cycles mid-burst while in1_valid=1:
- grant held;
- in1_ready=0 throughout;
- the burst resumes and completes.
